// File: rtl/steer_pkg.sv
// Shared types and default constants for the steering-enable stage.
// Holds the FSM state encoding, rider-weight thresholds and qualification terms.
// Build option: STEER_FAST_SIM_EN (used by steer_en_sm) selects TMR_TERM_FAST.
package steer_pkg;

    // 2'b11 is unused and treated as illegal by the FSM.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        STEER = 2'b10
    } steer_st_t;

    localparam logic [12:0] MIN_RIDER_WT_DEF = 13'h0200;
    localparam logic [12:0] WT_HYST_DEF      = 13'h0040;
    localparam logic [26:0] TMR_TERM_DEF     = 27'd67_000_000;

    // Short qualification term so simulations reach STEER quickly.
    localparam logic [26:0] TMR_TERM_FAST    = 27'd32_767;

endpackage

// File: rtl/steer_en_sm_ld_cmp.sv
// Load-cell arithmetic: sum, saturated difference and balance comparators.
// Latency: purely combinational, zero cycles.
// Backpressure: none, operates on the captured register values.
// Ports: lft_q/rght_q (captured 12-bit readings) in; sum, diff_sat,
//        diff_gt_1_4, diff_gt_15_16 out.
module ld_cmp (
    input  logic [11:0] lft_q,
    input  logic [11:0] rght_q,
    output logic [12:0] sum,
    output logic [11:0] diff_sat,
    output logic        diff_gt_1_4,
    output logic        diff_gt_15_16
);

    logic [12:0] diff;      // two's complement, range -4095..4095
    logic [12:0] diff_neg;
    logic [11:0] abs_diff;

    assign sum      = {1'b0, lft_q} + {1'b0, rght_q};
    assign diff     = {1'b0, lft_q} - {1'b0, rght_q};
    assign diff_neg = 13'd0 - diff;

    // |diff| is at most 4095, so the magnitude always fits in 12 bits.
    assign abs_diff = diff[12] ? diff_neg[11:0] : diff[11:0];

    // Bits 12 and 11 disagree exactly when the value is outside 12-bit signed range.
    always_comb begin
        diff_sat = diff[11:0];
        if (!diff[12] && diff[11])
            diff_sat = 12'h7FF;
        else if (diff[12] && !diff[11])
            diff_sat = 12'h800;
    end

    assign diff_gt_1_4   = {1'b0, abs_diff} > (sum >> 2);
    assign diff_gt_15_16 = {1'b0, abs_diff} > (sum - (sum >> 4));

endmodule

// File: rtl/steer_en_sm.sv
// Rider-detect and steering-enable FSM feeding the balance controller.
// Latency: ld_vld -> ld_cell_diff/rider_off 2 clocks; en_steer after full WAIT qualification.
// Backpressure: none; ld_vld is a single-cycle strobe, registers hold without it.
// Ports: clk, rst (async active-high), ld_vld, lft_ld, rght_ld in;
//        rider_off, en_steer, ld_cell_diff, steer_st out.
// Build option: define STEER_FAST_SIM_EN to force the qualification term to 32,767 clocks.
module steer_en_sm
    import steer_pkg::*;
#(
    parameter logic [12:0] MIN_RIDER_WT = MIN_RIDER_WT_DEF,
    parameter logic [12:0] WT_HYST      = WT_HYST_DEF,
    parameter logic [26:0] TMR_TERM     = TMR_TERM_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_vld,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        rider_off,
    output logic        en_steer,
    output logic [11:0] ld_cell_diff,
    output logic [1:0]  steer_st
);

`ifdef STEER_FAST_SIM_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif

    localparam logic [26:0] TERM      = FAST_EN ? TMR_TERM_FAST : TMR_TERM;
    localparam logic [26:0] TERM_LAST = TERM - 27'd1;
    localparam logic [12:0] LEAVE_WT  = MIN_RIDER_WT - WT_HYST;

    logic [11:0] lft_q;
    logic [11:0] rght_q;
    logic [12:0] sum;
    logic [11:0] diff_sat;
    logic        diff_gt_1_4;
    logic        diff_gt_15_16;

    steer_st_t   state_q;
    steer_st_t   state_nxt;
    logic [26:0] tmr_q;
    logic [26:0] tmr_nxt;

    // Input capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lft_q  <= 12'd0;
            rght_q <= 12'd0;
        end else if (ld_vld) begin
            lft_q  <= lft_ld;
            rght_q <= rght_ld;
        end
    end

    ld_cmp u_ld_cmp (
        .lft_q         (lft_q),
        .rght_q        (rght_q),
        .sum           (sum),
        .diff_sat      (diff_sat),
        .diff_gt_1_4   (diff_gt_1_4),
        .diff_gt_15_16 (diff_gt_15_16)
    );

    // Rider detect with hysteresis; between the two thresholds the flag holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rider_off    <= 1'b1;
            ld_cell_diff <= 12'd0;
        end else begin
            ld_cell_diff <= diff_sat;
            if (sum < LEAVE_WT)
                rider_off <= 1'b1;
            else if (sum >= MIN_RIDER_WT)
                rider_off <= 1'b0;
        end
    end

    // FSM state, timer and en_steer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            tmr_q    <= 27'd0;
            en_steer <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            tmr_q    <= tmr_nxt;
            // Registered from next state so it rises with the STEER entry edge.
            en_steer <= (state_nxt == STEER);
        end
    end

    // rider_off is tested first in every state so it wins over all else.
    // The timer stops at TERM_LAST because WAIT leaves for STEER there.
    always_comb begin
        state_nxt = state_q;
        tmr_nxt   = tmr_q;
        case (state_q)
            IDLE: begin
                if (!rider_off) begin
                    state_nxt = WAIT;
                    tmr_nxt   = 27'd0;
                end
            end
            WAIT: begin
                if (rider_off)
                    state_nxt = IDLE;
                else if (diff_gt_1_4)
                    tmr_nxt = 27'd0;
                else if (tmr_q == TERM_LAST)
                    state_nxt = STEER;
                else
                    tmr_nxt = tmr_q + 27'd1;
            end
            STEER: begin
                if (rider_off) begin
                    state_nxt = IDLE;
                end else if (diff_gt_15_16) begin
                    state_nxt = WAIT;
                    tmr_nxt   = 27'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                tmr_nxt   = 27'd0;
            end
        endcase
    end

    assign steer_st = state_q;

endmodule

// File: tb/tb_steer_en_sm.sv
module tb_steer_en_sm;

`ifdef STEER_FAST_SIM_EN
    localparam int TERM = 32767;
`else
    localparam int TERM = 40;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_vld = 1'b0;
    logic [11:0] lft_ld = 12'd0;
    logic [11:0] rght_ld = 12'd0;
    logic        rider_off;
    logic        en_steer;
    logic [11:0] ld_cell_diff;
    logic [1:0]  steer_st;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    steer_en_sm #(.TMR_TERM(27'd40)) dut (
        .clk          (clk),
        .rst          (rst),
        .ld_vld       (ld_vld),
        .lft_ld       (lft_ld),
        .rght_ld      (rght_ld),
        .rider_off    (rider_off),
        .en_steer     (en_steer),
        .ld_cell_diff (ld_cell_diff),
        .steer_st     (steer_st)
    );

    // Presents one pair for a single posedge; returns at the following negedge,
    // at which point the pair has been captured but outputs not yet updated.
    task automatic load(input logic [11:0] l, input logic [11:0] r);
        @(negedge clk);
        ld_vld  = 1'b1;
        lft_ld  = l;
        rght_ld = r;
        @(negedge clk);
        ld_vld  = 1'b0;
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        wait_neg(2);
        chk_cnt++; if (rider_off !== 1'b1) $display("FAIL reset_rider_off got %b want 1", rider_off); else pass_cnt++;
        chk_cnt++; if (en_steer !== 1'b0) $display("FAIL reset_en_steer got %b want 0", en_steer); else pass_cnt++;
        chk_cnt++; if (steer_st !== 2'b00) $display("FAIL reset_state got %b want 00", steer_st); else pass_cnt++;
        chk_cnt++; if (ld_cell_diff !== 12'h000) $display("FAIL reset_diff got %h want 000", ld_cell_diff); else pass_cnt++;
        rst = 1'b0;
        load(12'h000, 12'h000);
        wait_neg(2);
        chk_cnt++; if (rider_off !== 1'b1) $display("FAIL zero_rider_off got %b want 1", rider_off); else pass_cnt++;
        chk_cnt++; if (steer_st !== 2'b00) $display("FAIL zero_state got %b want 00", steer_st); else pass_cnt++;
        chk_cnt++; if (en_steer !== 1'b0) $display("FAIL zero_en_steer got %b want 0", en_steer); else pass_cnt++;
    endtask

    task automatic test_qualify;
        load(12'h180, 12'h180);
        wait_neg(1);
        chk_cnt++; if (rider_off !== 1'b0) $display("FAIL qual_rider_on got %b want 0", rider_off); else pass_cnt++;
        chk_cnt++; if (steer_st !== 2'b00) $display("FAIL qual_still_idle got %b want 00", steer_st); else pass_cnt++;
        wait_neg(1);
        chk_cnt++; if (steer_st !== 2'b01) $display("FAIL qual_enter_wait got %b want 01", steer_st); else pass_cnt++;
        // WAIT lasts exactly TERM clocks; one clock short must still be WAIT.
        wait_neg(TERM - 1);
        chk_cnt++; if (en_steer !== 1'b0) $display("FAIL qual_early_en got %b want 0", en_steer); else pass_cnt++;
        chk_cnt++; if (steer_st !== 2'b01) $display("FAIL qual_last_wait got %b want 01", steer_st); else pass_cnt++;
        wait_neg(1);
        chk_cnt++; if (en_steer !== 1'b1) $display("FAIL qual_en_steer got %b want 1", en_steer); else pass_cnt++;
        chk_cnt++; if (steer_st !== 2'b10) $display("FAIL qual_state_steer got %b want 10", steer_st); else pass_cnt++;
    endtask

    task automatic test_diff_15_16;
        load(12'h3F0, 12'h010);
        wait_neg(1);
        chk_cnt++; if (steer_st !== 2'b01) $display("FAIL d1516_state got %b want 01", steer_st); else pass_cnt++;
        chk_cnt++; if (en_steer !== 1'b0) $display("FAIL d1516_en_steer got %b want 0", en_steer); else pass_cnt++;
        chk_cnt++; if (ld_cell_diff !== 12'h3E0) $display("FAIL d1516_diff got %h want 3e0", ld_cell_diff); else pass_cnt++;
    endtask

    task automatic test_diff_1_4;
        int bad_en;
        int bad_st;
        int bad_tmr;
        bad_en = 0; bad_st = 0; bad_tmr = 0;
        load(12'h300, 12'h100);
        for (int i = 0; i < TERM + 4; i++) begin
            @(negedge clk);
            if (en_steer !== 1'b0) bad_en++;
            if (steer_st !== 2'b01) bad_st++;
            if (dut.tmr_q !== 27'd0) bad_tmr++;
        end
        chk_cnt++; if (bad_en != 0) $display("FAIL d14_en_steer got %0d high cycles want 0", bad_en); else pass_cnt++;
        chk_cnt++; if (bad_st != 0) $display("FAIL d14_state got %0d non-WAIT cycles want 0", bad_st); else pass_cnt++;
        chk_cnt++; if (bad_tmr != 0) $display("FAIL d14_tmr got %0d nonzero cycles want 0", bad_tmr); else pass_cnt++;
    endtask

    task automatic test_hysteresis;
        load(12'h0E8, 12'h0E8);   // sum 0x1D0, inside the hysteresis band
        wait_neg(2);
        chk_cnt++; if (rider_off !== 1'b0) $display("FAIL hyst_hold got %b want 0", rider_off); else pass_cnt++;
        chk_cnt++; if (steer_st !== 2'b01) $display("FAIL hyst_hold_state got %b want 01", steer_st); else pass_cnt++;
        load(12'h0D8, 12'h0D8);   // sum 0x1B0, below 0x1C0
        wait_neg(1);
        chk_cnt++; if (rider_off !== 1'b1) $display("FAIL hyst_leave got %b want 1", rider_off); else pass_cnt++;
        wait_neg(1);
        chk_cnt++; if (steer_st !== 2'b00) $display("FAIL hyst_idle got %b want 00", steer_st); else pass_cnt++;
    endtask

    task automatic test_saturation;
        load(12'hFFF, 12'h000);
        wait_neg(1);
        chk_cnt++; if (ld_cell_diff !== 12'h7FF) $display("FAIL sat_pos got %h want 7ff", ld_cell_diff); else pass_cnt++;
        load(12'h000, 12'hFFF);
        wait_neg(1);
        chk_cnt++; if (ld_cell_diff !== 12'h800) $display("FAIL sat_neg got %h want 800", ld_cell_diff); else pass_cnt++;
        load(12'h100, 12'h300);
        wait_neg(1);
        chk_cnt++; if (ld_cell_diff !== 12'hE00) $display("FAIL diff_neg got %h want e00", ld_cell_diff); else pass_cnt++;
    endtask

    task automatic test_reset_mid_wait;
        wait_neg(2);
        chk_cnt++; if (steer_st !== 2'b01) $display("FAIL rst_pre_wait got %b want 01", steer_st); else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        chk_cnt++; if (steer_st !== 2'b00) $display("FAIL rst_async_state got %b want 00", steer_st); else pass_cnt++;
        chk_cnt++; if (en_steer !== 1'b0) $display("FAIL rst_async_en got %b want 0", en_steer); else pass_cnt++;
        chk_cnt++; if (rider_off !== 1'b1) $display("FAIL rst_async_rider got %b want 1", rider_off); else pass_cnt++;
        chk_cnt++; if (ld_cell_diff !== 12'h000) $display("FAIL rst_async_diff got %h want 000", ld_cell_diff); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset;
        test_qualify;
        test_diff_15_16;
        test_diff_1_4;
        test_hysteresis;
        test_saturation;
        test_reset_mid_wait;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
